// File: rtl/lcd_bus_sched.sv
// HD44780 8-bit write-bus sequencer: power-on wait, fixed init list, then
// round-robin sharing of the bus between two {rs, data} requesters.
module lcd_bus_sched #(
  parameter int TICK_DIV   = 25,
  parameter int EN_TICKS   = 1,
  parameter int PWR_WAIT   = 15000,
  parameter int SHORT_WAIT = 40,
  parameter int LONG_WAIT  = 1530
) (
  input  logic       C,
  input  logic       RN,
  output logic       ENQ,
  output logic       TRSQ,
  output logic [7:0] DataQ,
  output logic       RWY,
  output logic       INIT_DONEQ,
  output logic       READYQ,
  input  logic       REQ0,
  input  logic       RS0,
  input  logic [7:0] DATA0,
  output logic       ACK0Q,
  input  logic       REQ1,
  input  logic       RS1,
  input  logic [7:0] DATA1,
  output logic       ACK1Q
);

  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_PWR, S_INIT, S_IDLE, S_SETUP, S_EN_HI, S_EN_LO, S_WAIT
  } state_t;

  state_t        r_state;
  logic [TW-1:0] r_tick;
  logic [13:0]   r_wait;
  logic [2:0]    r_idx;
  logic          r_ptr;
  logic          r_en, r_rs, r_ack0, r_ack1, r_ready, r_init_done;
  logic [7:0]    r_data;

  logic          w_tick, w_done, w_grant1;
  logic [13:0]   w_target;

  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0:    return 8'h38;
      3'd1:    return 8'h08;
      3'd2:    return 8'h01;
      3'd3:    return 8'h06;
      default: return 8'h0C;
    endcase
  endfunction

  // Ticks the current state must last; clear/home need the long execution wait.
  always_comb begin
    w_target = 14'd1;
    case (r_state)
      S_PWR:   w_target = 14'(PWR_WAIT);
      S_EN_HI: w_target = 14'(EN_TICKS);
      S_WAIT:  w_target = (!r_rs && r_data[7:2] == 6'd0) ? 14'(LONG_WAIT)
                                                        : 14'(SHORT_WAIT);
      default: w_target = 14'd1;
    endcase
  end

  assign w_tick   = (r_tick == TICK_LAST);
  assign w_done   = w_tick && (r_wait == w_target - 14'd1);
  // Requester 1 wins when alone, or on a tie when requester 0 was granted last.
  assign w_grant1 = REQ1 && (!REQ0 || !r_ptr);

  always_ff @(posedge C or negedge RN) begin
    if (!RN) begin
      r_state     <= S_PWR;
      r_tick      <= '0;
      r_wait      <= '0;
      r_idx       <= '0;
      r_ptr       <= 1'b0;
      r_en        <= 1'b0;
      r_rs        <= 1'b0;
      r_data      <= 8'h00;
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      r_ready     <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults first; a later assignment in the case
      // below overrides them, which is how each state change restarts the
      // prescaler and wait counter.
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      if (w_tick) begin
        r_tick <= '0;
        r_wait <= r_wait + 14'd1;
      end else begin
        r_tick <= r_tick + 1'b1;
      end

      case (r_state)
        S_PWR: if (w_done) begin
          r_state <= S_INIT;
          r_tick  <= '0;
          r_wait  <= '0;
        end
        S_INIT: begin
          r_rs    <= 1'b0;
          r_data  <= init_cmd(r_idx);
          r_state <= S_SETUP;
          r_tick  <= '0;
          r_wait  <= '0;
        end
        S_IDLE: if (REQ0 || REQ1) begin
          r_ptr   <= w_grant1;
          r_rs    <= w_grant1 ? RS1 : RS0;
          r_data  <= w_grant1 ? DATA1 : DATA0;
          r_ack1  <= w_grant1;
          r_ack0  <= !w_grant1;
          r_ready <= 1'b0;
          r_state <= S_SETUP;
          r_tick  <= '0;
          r_wait  <= '0;
        end
        S_SETUP: if (w_done) begin
          r_en    <= 1'b1;
          r_state <= S_EN_HI;
          r_tick  <= '0;
          r_wait  <= '0;
        end
        S_EN_HI: if (w_done) begin
          r_en    <= 1'b0;
          r_state <= S_EN_LO;
          r_tick  <= '0;
          r_wait  <= '0;
        end
        S_EN_LO: if (w_done) begin
          r_state <= S_WAIT;
          r_tick  <= '0;
          r_wait  <= '0;
        end
        S_WAIT: if (w_done) begin
          r_tick <= '0;
          r_wait <= '0;
          if (r_init_done) begin
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_idx <= r_idx + 3'd1;
            if (r_idx == 3'd4) begin
              r_init_done <= 1'b1;
              r_ready     <= 1'b1;
              r_state     <= S_IDLE;
            end else begin
              r_state <= S_INIT;
            end
          end
        end
        default: r_state <= S_PWR;
      endcase
    end
  end

  assign ENQ        = r_en;
  assign TRSQ       = r_rs;
  assign DataQ      = r_data;
  assign RWY        = 1'b0;
  assign INIT_DONEQ = r_init_done;
  assign READYQ     = r_ready;
  assign ACK0Q      = r_ack0;
  assign ACK1Q      = r_ack1;

endmodule
